// File: rtl/dadd_stepgen.sv
// dadd_stepgen: source-data phrase generator that steps four 16-bit lanes per accepted phrase
module dadd_stepgen #(
  parameter int LSHIFT = 2,
  parameter int CNTW = 16
) (
  input  logic            sys_clk,
  input  logic            resetl,
  input  logic            load,
  input  logic [63:0]     load_data,
  input  logic [31:0]     iinc,
  input  logic [31:0]     zinc,
  input  logic [1:0]      incsel,
  input  logic            clamp,
  input  logic [CNTW-1:0] count,
  input  logic            start,
  input  logic            abort,
  input  logic            stall,
  output logic [31:0]     srcdlo,
  output logic [31:0]     srcdhi,
  output logic            valid,
  output logic            busy,
  output logic            done
);
  localparam int W = 18 + LSHIFT;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [63:0] lanes, nxt;
  logic [CNTW-1:0] rem;
  logic [1:0] sel;
  logic clp;
  logic [15:0] word;
  logic [W-1:0] incx, sum;
  assign word = sel == 2'd0 ? iinc[15:0] : sel == 2'd1 ? iinc[31:16] : sel == 2'd2 ? zinc[15:0] : zinc[31:16];
  assign incx = {{(W-16){word[15]}}, word} << LSHIFT;
  assign srcdlo = lanes[31:0];
  assign srcdhi = lanes[63:32];
  // next lane values: wrapping add, or a wide signed sum saturated to the unsigned 16-bit range
  always_comb begin
    nxt = lanes;
    sum = '0;
    for (int k = 0; k < 4; k++) begin
      sum = {{(W-16){1'b0}}, lanes[16*k +: 16]} + incx;
      nxt[16*k +: 16] = !clp ? lanes[16*k +: 16] + incx[15:0] : sum[W-1] ? 16'h0000 : |sum[W-2:16] ? 16'hFFFF : sum[15:0];
    end
  end
  // run sequencer with registered handshake outputs; abort overrides everything
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state <= IDLE;
      lanes <= '0;
      rem <= '0;
      sel <= '0;
      clp <= 1'b0;
      valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) lanes <= load_data;
          if (start) begin
            busy <= 1'b1;
            if (count != '0) begin
              sel <= incsel;
              clp <= clamp;
              rem <= count;
              valid <= 1'b1;
              state <= RUN;
            end else begin
              done <= 1'b1;
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (valid && !stall) begin
            lanes <= nxt;
            rem <= rem - 1'b1;
            if (rem == CNTW'(1)) begin
              valid <= 1'b0;
              done <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
